// File: rtl/alu_op_arbiter.sv
// Two-requester arbiter sharing one ALU: issue for one cycle, capture result and
// post-update flags, return them through a valid/ready response. Supports locked bursts.
module alu_op_arbiter #(
    parameter int unsigned PRIORITY_MODE = 0,
    parameter int unsigned LOCK_MAX      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_funsel,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req0_wf,
    input  logic        req0_lock,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_funsel,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic        req1_wf,
    input  logic        req1_lock,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_funsel,
    output logic        alu_wf,
    input  logic [15:0] alu_out,
    input  logic [3:0]  alu_flags,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {StIdle, StIssue, StFlag, StResp} state_e;

    localparam logic [3:0] LockMax = 4'(LOCK_MAX);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic        lock_q, lock_d;
    logic [3:0]  lock_cnt_q, lock_cnt_d;
    logic [4:0]  funsel_q, funsel_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        wf_q, wf_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  flags_q, flags_d;

    logic [1:0]  req_valid;
    logic        win_valid;
    logic        win_id;
    logic        lock_hold;

    assign req_valid = {req1_valid, req0_valid};
    assign lock_hold = lock_q && req_valid[owner_q];

    always_comb begin
        win_valid = 1'b0;
        win_id    = 1'b0;
        if (lock_hold) begin
            // Owner keeps the grant until the cap is hit while the other side waits.
            win_valid = 1'b1;
            if (lock_cnt_q < LockMax || !req_valid[~owner_q]) begin
                win_id = owner_q;
            end else begin
                win_id = ~owner_q;
            end
        end else begin
            case (req_valid)
                2'b01: begin
                    win_valid = 1'b1;
                    win_id    = 1'b0;
                end
                2'b10: begin
                    win_valid = 1'b1;
                    win_id    = 1'b1;
                end
                2'b11: begin
                    win_valid = 1'b1;
                    win_id    = (PRIORITY_MODE == 0) ? ~last_grant_q : 1'b0;
                end
                default: begin
                    win_valid = 1'b0;
                    win_id    = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        lock_cnt_d   = lock_cnt_q;
        funsel_d     = funsel_q;
        a_d          = a_q;
        b_d          = b_q;
        wf_d         = wf_q;
        result_d     = result_q;
        flags_d      = flags_q;
        case (state_q)
            StIdle: begin
                if (lock_q && !req_valid[owner_q]) begin
                    lock_d = 1'b0;
                end
                if (win_valid) begin
                    owner_d  = win_id;
                    funsel_d = win_id ? req1_funsel : req0_funsel;
                    a_d      = win_id ? req1_a : req0_a;
                    b_d      = win_id ? req1_b : req0_b;
                    wf_d     = win_id ? req1_wf : req0_wf;
                    lock_d   = win_id ? req1_lock : req0_lock;
                    if (lock_hold && win_id == owner_q) begin
                        lock_cnt_d = (lock_cnt_q == 4'hF) ? 4'hF : lock_cnt_q + 4'd1;
                    end else begin
                        lock_cnt_d = 4'd1;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                result_d = alu_out;
                state_d  = StFlag;
            end
            StFlag: begin
                // Flags were committed by the ALU on the previous edge.
                flags_d = alu_flags;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    last_grant_d = owner_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            lock_q       <= 1'b0;
            lock_cnt_q   <= 4'd0;
            funsel_q     <= 5'd0;
            a_q          <= 16'd0;
            b_q          <= 16'd0;
            wf_q         <= 1'b0;
            result_q     <= 16'd0;
            flags_q      <= 4'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            lock_cnt_q   <= lock_cnt_d;
            funsel_q     <= funsel_d;
            a_q          <= a_d;
            b_q          <= b_d;
            wf_q         <= wf_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
        end
    end

    assign req0_ready = rst_n && (state_q == StIdle) && win_valid && !win_id;
    assign req1_ready = rst_n && (state_q == StIdle) && win_valid && win_id;
    assign rsp0_valid = (state_q == StResp) && !owner_q;
    assign rsp1_valid = (state_q == StResp) && owner_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_funsel = funsel_q;
    assign alu_wf     = (state_q == StIssue) && wf_q;
    assign busy       = (state_q != StIdle);
    assign grant_id   = owner_q;

endmodule

// File: doc/alu_op_arbiter.md
Name: alu_op_arbiter

Overview:
- Shares one ArithmeticLogicUnit instance between two requesters, e.g. the instruction sequencer and a DMA/address-calc unit.
- Arbitrates requests and drives the ALU's A/B/FunSel/WF inputs for exactly one cycle.
- Captures ALUOut and the registered FlagsOut, then returns both to the winner through a valid/ready response.
- Supports locked bursts, so multi-word add-with-carry chains are not interleaved with the other requester's flag updates.

Parameters:
PRIORITY_MODE, 0, 0 = round-robin; 1 = requester 0 wins every unlocked conflict
LOCK_MAX, 4, max consecutive locked grants to one requester while the other is waiting (range 1..15)

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_funsel  in  5  ALU function select
req0_a  in  16  operand A
req0_b  in  16  operand B
req0_wf  in  1  write ALU flags for this op
req0_lock  in  1  keep the grant for the next op
req1_valid, req1_ready, req1_funsel, req1_a, req1_b, req1_wf, req1_lock  same as above, for requester 1
rsp0_valid  out  1  response for requester 0
rsp1_valid  out  1  response for requester 1
rsp_ready  in  1  owner of the asserted rsp valid consumes the response
rsp_result  out  16  captured ALUOut
rsp_flags  out  4  captured FlagsOut, Z|C|N|O
alu_a  out  16  to ALU A
alu_b  out  16  to ALU B
alu_funsel  out  5  to ALU FunSel
alu_wf  out  1  to ALU WF
alu_out  in  16  from ALU ALUOut
alu_flags  in  4  from ALU FlagsOut
busy  out  1  state != IDLE
grant_id  out  1  requester owning the current or last op

Behaviour:
- Reset (async, Reset=0):
  - state=IDLE; all outputs 0; last_grant=1, so requester 0 wins the first conflict; lock_cnt=0; locked owner cleared.
  - alu_wf drops to 0 immediately.
  - An in-flight op is abandoned with no response; ALU flags may already hold its update.
- FSM states: IDLE -> ISSUE -> FLAG -> RESP -> IDLE.
- IDLE:
  - Combinational grant; reqN_ready=1 only for the selected requester, only in IDLE, only while its valid=1.
  - Accept on valid&&ready: latch funsel/a/b/wf/lock and the owner, set grant_id, go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE (1 cycle):
  - alu_a/alu_b/alu_funsel driven from the latched values; alu_wf=latched wf.
  - At the closing edge: rsp_result<=alu_out; the ALU writes its flags on the same edge.
- FLAG (1 cycle):
  - alu_wf=0; alu_a/alu_b/alu_funsel hold their values.
  - At the closing edge: rsp_flags<=alu_flags, i.e. the post-update flags.
- RESP:
  - rspN_valid=1 for the owner; rsp_result and rsp_flags stay stable until rsp_ready.
  - On rsp_ready: valid drops, last_grant<=owner, go to IDLE.
- Latency and throughput:
  - Accept at edge T → rsp valid from cycle T+3.
  - Best throughput is 1 op per 4 cycles.
  - A new request can be accepted in the first IDLE cycle after rsp_ready.
- Arbitration, in priority order:
  1. Locked owner: if the previous accepted op had lock=1, the owner has valid, and (lock_cnt<LOCK_MAX or the other requester has no valid), the owner wins.
  2. Only one valid: that requester wins.
  3. Both valid, PRIORITY_MODE=0: !last_grant wins.
  4. Both valid, PRIORITY_MODE=1: requester 0 wins.
- Lock counting and release:
  - lock_cnt increments on each accept that is a consecutive grant to the same requester with lock set on the prior op.
  - Otherwise lock_cnt resets to 1 on an accept.
  - If the locked owner has no valid in the IDLE cycle, the lock is released and normal arbitration applies.
  - When lock_cnt reaches LOCK_MAX with the other requester waiting, the grant is forced to the other requester and lock_cnt=1.
- Unselected requester: reqN_ready=0; its inputs are ignored, never sampled.
- wf=0 op: rsp_flags still captures alu_flags, which are unchanged.
- Outside ISSUE, alu_wf is always 0, so the ALU's combinational flag calculations never commit.

Test Plan:
- Single op: req0 funsel=10100, a=0x7FFF, b=0x0001, wf=1 → rsp0_valid at accept+3; result=0x8000; flags Z=0, C=0, N=1, O=1; req1 idle.
- Conflict, round-robin: both valid at the first IDLE after reset → grant order 0,1,0,1; each rsp_result matches the requester's own operands (00111 AND, 11001 XOR).
- Locked ADC chain, LOCK_MAX=4: req0 issues lock=1 ops 10100 then 10101 while req1 is valid → req0 gets 2 consecutive grants; the second result includes the carry from 0xFFFF+0x0001; then req1 is granted.
- Lock cap: req0 asserts lock=1 continuously with req1 waiting → exactly 4 req0 grants, then req1.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_result/rsp_flags stable; req0_ready and req1_ready stay 0 throughout.
- Reset mid-op: Reset=0 during FLAG → all outputs 0 that cycle; after release, a new req1 op completes normally in 4 cycles.
